// File: rtl/multiword_add_sequencer.sv
// Multi-word add/subtract sequencer: chains carry across a burst of operand
// words (least-significant first) and emits one registered sum word per beat,
// reporting the final carry/borrow and signed overflow with the last beat.
module multiword_add_sequencer #(
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned MAX_WORDS  = 8
) (
    input  logic                                                  i_clk,
    input  logic                                                  i_rst_n,
    input  logic                                                  i_valid,
    output logic                                                  o_ready,
    input  logic [WORD_WIDTH-1:0]                                 i_a,
    input  logic [WORD_WIDTH-1:0]                                 i_b,
    input  logic                                                  i_sub,
    input  logic                                                  i_last,
    output logic                                                  o_valid,
    input  logic                                                  i_ready,
    output logic [WORD_WIDTH-1:0]                                 o_sum,
    output logic                                                  o_last,
    output logic                                                  o_carry,
    output logic                                                  o_ovf,
    output logic                                                  o_err,
    output logic [((MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1)-1:0] o_beat_idx
);

    localparam int unsigned CNT_W = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam int unsigned SUM_W = WORD_WIDTH + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WORDS - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    logic [0:0]            state;
    logic [0:0]            state_nx;
    logic                  carry_q;
    logic                  sub_q;
    logic [CNT_W-1:0]      cnt;

    logic                  accept;
    logic                  fire;
    logic                  in_idle;
    logic                  sub_eff;
    logic                  cin;
    logic [WORD_WIDTH-1:0] b_eff;
    logic [SUM_W-1:0]      sum_full;
    logic                  cout;
    logic                  cout_into_msb;
    logic                  cnt_at_max;

    // Handshake: a single output register, refilled in the same cycle it drains.
    assign o_ready = !o_valid || i_ready;
    assign accept  = i_valid && o_ready;
    assign fire    = o_valid && i_ready;

    // Per-beat adder: operation and carry-in come from the burst context.
    always_comb begin
        in_idle       = (state == S_IDLE);
        sub_eff       = in_idle ? i_sub : sub_q;
        b_eff         = sub_eff ? ~i_b : i_b;
        cin           = in_idle ? sub_eff : carry_q;
        sum_full      = SUM_W'(i_a) + SUM_W'(b_eff) + SUM_W'(cin);
        cout          = sum_full[WORD_WIDTH];
        cout_into_msb = i_a[WORD_WIDTH-1] ^ b_eff[WORD_WIDTH-1] ^ sum_full[WORD_WIDTH-1];
        cnt_at_max    = (cnt == CNT_MAX);
    end

    // Next-state: a non-last beat opens a burst, a last beat closes it.
    always_comb begin
        state_nx = state;
        if (accept) begin
            state_nx = i_last ? S_IDLE : S_BURST;
        end
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Burst context: chained carry, latched operation, beat counter, error flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            cnt     <= '0;
            o_err   <= 1'b0;
        end else if (accept) begin
            carry_q <= i_last ? 1'b0 : cout;
            if (in_idle) begin
                sub_q <= i_sub;
            end
            if (i_last) begin
                cnt <= '0;
            end else if (cnt_at_max) begin
                o_err <= 1'b1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Output register: load on accept, drop valid on a drain with no refill.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid    <= 1'b0;
            o_sum      <= '0;
            o_last     <= 1'b0;
            o_carry    <= 1'b0;
            o_ovf      <= 1'b0;
            o_beat_idx <= '0;
        end else if (accept) begin
            o_valid    <= 1'b1;
            o_sum      <= sum_full[WORD_WIDTH-1:0];
            o_last     <= i_last;
            o_carry    <= i_last ? cout : 1'b0;
            o_ovf      <= i_last ? (cout_into_msb ^ cout) : 1'b0;
            o_beat_idx <= cnt;
        end else if (fire) begin
            o_valid <= 1'b0;
        end
    end

endmodule
